frame_buffer_sequencer: RTL and testbench
=========================================

FRAME_BUFFER_SEQUENCER -- requirements
Module: frame_buffer_sequencer

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 307200, pixels per complete frame (640*480).
REQ-002 SHALL have parameter BUF0_BASE, default 22'h000000, SDRAM word base of buffer 0.
REQ-003 SHALL have parameter BUF1_BASE, default 22'h100000, SDRAM word base of buffer 1.
REQ-004 SHALL have parameter CLK_HZ, default 25000000, clk frequency for the rate window.
REQ-005 SHALL have port clk  in  1  single clock; all inputs are synchronous to it.
REQ-006 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port capture_en  in  1  level; 0 stops new captures.
REQ-008 SHALL have port cam_frame_start  in  1  one-cycle pulse at camera frame start.
REQ-009 SHALL have port cam_pix_valid  in  1  pixel strobe from synchronizer.
REQ-010 SHALL have port vga_frame_start  in  1  one-cycle pulse at VGA vertical blank.
REQ-011 SHALL have ports wr_base / rd_base  out  22  SDRAM write / read FIFO base address.
REQ-012 SHALL have ports wr_load / rd_load  out  1  one-cycle FIFO address-load pulses.
REQ-013 SHALL have port wr_en  out  1  gated pixel write enable to SDRAM write FIFO.
REQ-014 SHALL have ports frame_done  out 1  pulse; short_err  out 1  pulse; drop_cnt  out 16; rate  out 32.

Function
REQ-015 SHALL run FSM IDLE, ARMED, CAPTURE, WAIT_SWAP; IDLE->ARMED when capture_en=1.
REQ-016 ARMED->CAPTURE on cam_frame_start: pixel counter cleared, wr_base = base of wr_sel, wr_load pulsed next cycle.
REQ-017 In CAPTURE, wr_en SHALL equal cam_pix_valid delayed one cycle; wr_en=0 in all other states.
REQ-018 Pixel counter SHALL increment per cam_pix_valid; at count FRAME_PIXELS: frame_done pulse, ready buffer = wr_sel, ->WAIT_SWAP; further pixels ignored.
REQ-019 cam_frame_start in CAPTURE before count reaches FRAME_PIXELS SHALL pulse short_err and restart capture in same buffer (counter cleared, wr_load pulsed).
REQ-020 On vga_frame_start with ready pending: rd_sel <= ready buffer, rd_base updated, rd_load pulsed next cycle, pending cleared, wr_sel <= other buffer.
REQ-021 vga_frame_start without pending frame SHALL re-pulse rd_load with unchanged rd_base (frame repeat).
REQ-022 WAIT_SWAP->ARMED (or IDLE if capture_en=0) the cycle after swap; cam_frame_start in WAIT_SWAP increments drop_cnt, saturating at 16'hFFFF.
REQ-023 Writer SHALL never target the buffer currently selected by rd_sel.
REQ-024 capture_en=0 SHALL be honoured only at frame boundaries: CAPTURE completes current frame, ARMED returns to IDLE.
REQ-025 Simultaneous frame completion and vga_frame_start SHALL commit first; swap occurs on the next vga_frame_start.

Reset
REQ-026 Reset SHALL force IDLE, wr_sel=0, rd_sel=1, pending=0, counters=0, wr_base=BUF0_BASE, rd_base=BUF1_BASE.
REQ-027 All pulse outputs, wr_en, drop_cnt, rate SHALL be 0 during and after reset; mid-frame reset discards the partial frame.

Configuration
REQ-028 Macro FRAME_RATE_EN defined: rate SHALL hold completed frames counted in last CLK_HZ-cycle window, updated at window end.
REQ-029 Macro FRAME_RATE_EN undefined: rate SHALL be constant 0 and no window logic synthesized.

Structure
REQ-030 Package fb_seq_pkg SHALL hold FSM state enum, ADDR_W=22, and buffer-select type.
REQ-031 Rate window SHALL be sub-module frame_rate_counter, instantiated only under FRAME_RATE_EN.

Verification (FRAME_PIXELS=16, CLK_HZ=1000)
REQ-032 capture_en=1, start, 16 valid -> wr_load once, 16 wr_en, frame_done on 16th, WAIT_SWAP.
REQ-033 Then vga_frame_start -> rd_base=BUF0_BASE, rd_load 1 cycle later, next capture uses wr_base=BUF1_BASE.
REQ-034 start, 10 valid, start -> short_err=1, counter restarts, wr_base unchanged.
REQ-035 Three cam_frame_start in WAIT_SWAP, no VGA -> drop_cnt=3, wr_en stays 0.
REQ-036 Reset asserted after 8 pixels -> IDLE, outputs 0, rd_base=BUF1_BASE; FRAME_RATE_EN with 5 frames per window -> rate=5.

Source files
------------

// File: rtl/frame_buffer_sequencer_pkg.sv
// ============================================================================
// Module  : fb_seq_pkg
// Brief   : Shared types and constants for the frame buffer sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_seq_pkg;

    localparam int ADDR_W = 22;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } fb_state_e;

    typedef enum logic {
        BUF_0 = 1'b0,
        BUF_1 = 1'b1
    } buf_sel_e;

endpackage

`default_nettype wire

// File: rtl/frame_buffer_sequencer_if.sv
// ============================================================================
// Module  : frame_buffer_sequencer_if
// Brief   : SDRAM FIFO address/load/write-enable bundle of the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_buffer_sequencer_if;
    import fb_seq_pkg::*;

    logic [ADDR_W-1:0] wr_base;
    logic [ADDR_W-1:0] rd_base;
    logic              wr_load;
    logic              rd_load;
    logic              wr_en;

    modport master (output wr_base, output rd_base, output wr_load, output rd_load, output wr_en);
    modport slave  (input  wr_base, input  rd_base, input  wr_load, input  rd_load, input  wr_en);
endinterface

`default_nettype wire

// File: rtl/frame_buffer_sequencer_frame_rate_counter.sv
// ============================================================================
// Module  : frame_rate_counter
// Brief   : Counts completed frames per CLK_HZ-cycle window (FRAME_RATE_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_rate_counter #(
    parameter int CLK_HZ = 25000000
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        frame_done,
    output logic [31:0]      rate
);
    localparam int WIN_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [WIN_W-1:0] r_win;
    logic [31:0]      r_frames;

    // A completion landing on the last window cycle still counts in that window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win    <= '0;
            r_frames <= '0;
            rate     <= '0;
        end else if (r_win == WIN_W'(CLK_HZ - 1)) begin
            r_win    <= '0;
            r_frames <= '0;
            rate     <= r_frames + {31'd0, frame_done};
        end else begin
            r_win    <= r_win + 1'b1;
            r_frames <= r_frames + {31'd0, frame_done};
        end
    end
endmodule

`default_nettype wire

// File: rtl/frame_buffer_sequencer.sv
// ============================================================================
// Module  : frame_buffer_sequencer
// Brief   : Double-buffer capture/display sequencer; FRAME_RATE_EN adds rate.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_buffer_sequencer
    import fb_seq_pkg::*;
#(
    parameter int                FRAME_PIXELS = 307200,
    parameter logic [ADDR_W-1:0] BUF0_BASE    = 22'h000000,
    parameter logic [ADDR_W-1:0] BUF1_BASE    = 22'h100000,
    parameter int                CLK_HZ       = 25000000
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              capture_en,
    input  wire logic              cam_frame_start,
    input  wire logic              cam_pix_valid,
    input  wire logic              vga_frame_start,
    frame_buffer_sequencer_if.master sdram,
    output logic                   frame_done,
    output logic                   short_err,
    output logic [15:0]            drop_cnt,
    output logic [31:0]            rate
);
    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);

    fb_state_e         r_state, w_state_next;
    logic [CNT_W-1:0]  r_pix_cnt;
    buf_sel_e          r_wr_sel, r_rd_sel, r_ready_sel;
    logic              r_pending;
    logic [ADDR_W-1:0] r_wr_base, r_rd_base;
    logic              r_wr_load, r_rd_load, r_wr_en, r_frame_done, r_short_err;
    logic [15:0]       r_drop_cnt;
    logic              w_start, w_restart, w_pix, w_complete, w_drop, w_swap, w_last;

    function automatic logic [ADDR_W-1:0] buf_base(input buf_sel_e sel);
        return (sel == BUF_1) ? BUF1_BASE : BUF0_BASE;
    endfunction

    assign w_last = (r_pix_cnt == CNT_W'(FRAME_PIXELS - 1));
    // pending is registered, so a completion coinciding with vblank swaps one vblank later
    assign w_swap = vga_frame_start && r_pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_restart    = 1'b0;
        w_pix        = 1'b0;
        w_complete   = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: if (capture_en) w_state_next = ST_ARMED;
            ST_ARMED: begin
                if (!capture_en) begin
                    w_state_next = ST_IDLE;
                end else if (cam_frame_start) begin
                    w_start      = 1'b1;
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (cam_frame_start) begin
                    w_restart = 1'b1;
                end else if (cam_pix_valid) begin
                    w_pix = 1'b1;
                    if (w_last) begin
                        w_complete   = 1'b1;
                        w_state_next = ST_WAIT_SWAP;
                    end
                end
            end
            ST_WAIT_SWAP: begin
                w_drop = cam_frame_start;
                if (!r_pending) w_state_next = capture_en ? ST_ARMED : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_cnt    <= '0;
            r_wr_sel     <= BUF_0;
            r_rd_sel     <= BUF_1;
            r_ready_sel  <= BUF_0;
            r_pending    <= 1'b0;
            r_wr_base    <= BUF0_BASE;
            r_rd_base    <= BUF1_BASE;
            r_wr_load    <= 1'b0;
            r_rd_load    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_short_err  <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_wr_load    <= w_start || w_restart;
            r_short_err  <= w_restart;
            r_wr_en      <= w_pix;
            r_frame_done <= w_complete;
            r_rd_load    <= vga_frame_start;
            if (w_start || w_restart) begin
                r_pix_cnt <= '0;
                r_wr_base <= buf_base(r_wr_sel);
            end else if (w_pix) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
            if (w_complete) begin
                r_ready_sel <= r_wr_sel;
                r_pending   <= 1'b1;
            end
            // Writer always moves to the buffer the display is not reading
            if (w_swap) begin
                r_rd_sel  <= r_ready_sel;
                r_rd_base <= buf_base(r_ready_sel);
                r_wr_sel  <= (r_ready_sel == BUF_0) ? BUF_1 : BUF_0;
                r_pending <= 1'b0;
            end
            if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign sdram.wr_base = r_wr_base;
    assign sdram.rd_base = r_rd_base;
    assign sdram.wr_load = r_wr_load;
    assign sdram.rd_load = r_rd_load;
    assign sdram.wr_en   = r_wr_en;
    assign frame_done    = r_frame_done;
    assign short_err     = r_short_err;
    assign drop_cnt      = r_drop_cnt;

`ifdef FRAME_RATE_EN
    frame_rate_counter #(
        .CLK_HZ     (CLK_HZ)
    ) u_frame_rate_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_done (r_frame_done),
        .rate       (rate)
    );
`else
    localparam int c_unused_clk_hz = CLK_HZ;
    assign rate = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_buffer_sequencer.sv
// ============================================================================
// Module  : tb_frame_buffer_sequencer
// Brief   : Directed self-checking bench for frame_buffer_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_buffer_sequencer;
    import fb_seq_pkg::*;

    localparam logic [ADDR_W-1:0] c_buf0 = 22'h000000;
    localparam logic [ADDR_W-1:0] c_buf1 = 22'h100000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        capture_en = 1'b0;
    logic        cam_frame_start = 1'b0;
    logic        cam_pix_valid = 1'b0;
    logic        vga_frame_start = 1'b0;
    logic        frame_done, short_err;
    logic [15:0] drop_cnt;
    logic [31:0] rate;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;

    frame_buffer_sequencer_if sdram_bus ();

    frame_buffer_sequencer #(
        .FRAME_PIXELS    (16),
        .BUF0_BASE       (c_buf0),
        .BUF1_BASE       (c_buf1),
        .CLK_HZ          (1000)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .capture_en      (capture_en),
        .cam_frame_start (cam_frame_start),
        .cam_pix_valid   (cam_pix_valid),
        .vga_frame_start (vga_frame_start),
        .sdram           (sdram_bus.master),
        .frame_done      (frame_done),
        .short_err       (short_err),
        .drop_cnt        (drop_cnt),
        .rate            (rate)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one full capture from ARMED through the swap and back to ARMED.
    task automatic run_frame();
        for (int k = 0; k < 20 && dut.r_state != ST_ARMED; k++) step();
        cam_frame_start = 1'b1; step(); cam_frame_start = 1'b0;
        cam_pix_valid = 1'b1;
        for (int k = 0; k < 16; k++) step();
        cam_pix_valid = 1'b0;
        vga_frame_start = 1'b1; step(); vga_frame_start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        n_checks++; if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.r_state, ST_IDLE); end
        n_checks++; if (sdram_bus.wr_base !== c_buf0) begin n_fail++; $display("FAIL reset_wr_base: got %h expected %h", sdram_bus.wr_base, c_buf0); end
        n_checks++; if (sdram_bus.rd_base !== c_buf1) begin n_fail++; $display("FAIL reset_rd_base: got %h expected %h", sdram_bus.rd_base, c_buf1); end
        n_checks++; if ({sdram_bus.wr_en, sdram_bus.wr_load, sdram_bus.rd_load, frame_done, short_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 00000", {sdram_bus.wr_en, sdram_bus.wr_load, sdram_bus.rd_load, frame_done, short_err}); end
        n_checks++; if (drop_cnt !== 16'd0 || rate !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got drop %0d rate %0d expected 0 0", drop_cnt, rate); end
        reset_n = 1'b1;
        step();
        n_checks++; if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL idle_hold: got %0d expected %0d", dut.r_state, ST_IDLE); end
    endtask

    task automatic test_capture();
        int n_wr_en = 0, n_wr_load = 0, n_fd = 0, fd_idx = -1;
        capture_en = 1'b1;
        step();
        n_checks++; if (dut.r_state !== ST_ARMED) begin n_fail++; $display("FAIL armed: got %0d expected %0d", dut.r_state, ST_ARMED); end
        cam_frame_start = 1'b1; step(); cam_frame_start = 1'b0;
        n_checks++; if (sdram_bus.wr_load !== 1'b1 || sdram_bus.wr_base !== c_buf0) begin
            n_fail++; $display("FAIL first_load: got load %b base %h expected 1 %h", sdram_bus.wr_load, sdram_bus.wr_base, c_buf0); end
        cam_pix_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            n_wr_en   += int'(sdram_bus.wr_en);
            n_wr_load += int'(sdram_bus.wr_load);
            if (frame_done) begin n_fd++; fd_idx = i; end
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_wr_en += int'(sdram_bus.wr_en);
        end
        cam_pix_valid = 1'b0;
        n_checks++; if (n_wr_en !== 16 || n_wr_load !== 0) begin n_fail++; $display("FAIL capture_counts: got wr_en %0d wr_load %0d expected 16 0", n_wr_en, n_wr_load); end
        n_checks++; if (n_fd !== 1 || fd_idx !== 15) begin n_fail++; $display("FAIL frame_done: got %0d pulses at %0d expected 1 at 15", n_fd, fd_idx); end
        n_checks++; if (dut.r_state !== ST_WAIT_SWAP) begin n_fail++; $display("FAIL wait_swap: got %0d expected %0d", dut.r_state, ST_WAIT_SWAP); end
    endtask

    task automatic test_swap();
        vga_frame_start = 1'b1; step(); vga_frame_start = 1'b0;
        n_checks++; if (sdram_bus.rd_base !== c_buf0 || sdram_bus.rd_load !== 1'b1) begin
            n_fail++; $display("FAIL swap: got rd_base %h rd_load %b expected %h 1", sdram_bus.rd_base, sdram_bus.rd_load, c_buf0); end
        step();
        n_checks++; if (dut.r_state !== ST_ARMED || sdram_bus.rd_load !== 1'b0) begin
            n_fail++; $display("FAIL post_swap: got state %0d rd_load %b expected %0d 0", dut.r_state, sdram_bus.rd_load, ST_ARMED); end
        cam_frame_start = 1'b1; step(); cam_frame_start = 1'b0;
        n_checks++; if (sdram_bus.wr_base !== c_buf1 || sdram_bus.wr_load !== 1'b1) begin
            n_fail++; $display("FAIL next_wr_base: got %h load %b expected %h 1", sdram_bus.wr_base, sdram_bus.wr_load, c_buf1); end
    endtask

    task automatic test_short_frame();
        int fd_idx = -1;
        cam_pix_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        cam_pix_valid = 1'b0;
        cam_frame_start = 1'b1; step(); cam_frame_start = 1'b0;
        n_checks++; if (short_err !== 1'b1 || sdram_bus.wr_load !== 1'b1) begin
            n_fail++; $display("FAIL short_err: got err %b load %b expected 1 1", short_err, sdram_bus.wr_load); end
        n_checks++; if (sdram_bus.wr_base !== c_buf1 || dut.r_pix_cnt !== 0) begin
            n_fail++; $display("FAIL short_restart: got base %h cnt %0d expected %h 0", sdram_bus.wr_base, dut.r_pix_cnt, c_buf1); end
        cam_pix_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (frame_done && fd_idx < 0) fd_idx = i;
        end
        cam_pix_valid = 1'b0;
        n_checks++; if (fd_idx !== 15) begin n_fail++; $display("FAIL restart_len: got done at %0d expected 15", fd_idx); end
    endtask

    task automatic test_drop();
        int n_wr_en = 0;
        for (int i = 0; i < 3; i++) begin
            cam_frame_start = 1'b1; cam_pix_valid = 1'b1; step();
            n_wr_en += int'(sdram_bus.wr_en);
            cam_frame_start = 1'b0; step();
            n_wr_en += int'(sdram_bus.wr_en);
        end
        cam_pix_valid = 1'b0;
        n_checks++; if (drop_cnt !== 16'd3 || n_wr_en !== 0) begin
            n_fail++; $display("FAIL drop: got drop %0d wr_en %0d expected 3 0", drop_cnt, n_wr_en); end
        vga_frame_start = 1'b1; step(); vga_frame_start = 1'b0;
        n_checks++; if (sdram_bus.rd_base !== c_buf1) begin n_fail++; $display("FAIL swap_buf1: got %h expected %h", sdram_bus.rd_base, c_buf1); end
        step();
        vga_frame_start = 1'b1; step(); vga_frame_start = 1'b0;
        n_checks++; if (sdram_bus.rd_load !== 1'b1 || sdram_bus.rd_base !== c_buf1) begin
            n_fail++; $display("FAIL repeat: got load %b base %h expected 1 %h", sdram_bus.rd_load, sdram_bus.rd_base, c_buf1); end
    endtask

    task automatic test_simultaneous();
        cam_frame_start = 1'b1; step(); cam_frame_start = 1'b0;
        n_checks++; if (sdram_bus.wr_base !== c_buf0) begin n_fail++; $display("FAIL sim_wr_base: got %h expected %h", sdram_bus.wr_base, c_buf0); end
        cam_pix_valid = 1'b1;
        for (int i = 0; i < 15; i++) step();
        vga_frame_start = 1'b1; step(); vga_frame_start = 1'b0; cam_pix_valid = 1'b0;
        n_checks++; if (frame_done !== 1'b1 || sdram_bus.rd_load !== 1'b1 || sdram_bus.rd_base !== c_buf1) begin
            n_fail++; $display("FAIL simultaneous: got done %b load %b base %h expected 1 1 %h", frame_done, sdram_bus.rd_load, sdram_bus.rd_base, c_buf1); end
        step();
        vga_frame_start = 1'b1; step(); vga_frame_start = 1'b0;
        n_checks++; if (sdram_bus.rd_base !== c_buf0) begin n_fail++; $display("FAIL deferred_swap: got %h expected %h", sdram_bus.rd_base, c_buf0); end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 20 && dut.r_state != ST_ARMED; k++) step();
        cam_frame_start = 1'b1; step(); cam_frame_start = 1'b0;
        cam_pix_valid = 1'b1;
        for (int i = 0; i < 8; i++) step();
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (dut.r_state !== ST_IDLE || sdram_bus.wr_en !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got state %0d wr_en %b expected %0d 0", dut.r_state, sdram_bus.wr_en, ST_IDLE); end
        n_checks++; if (sdram_bus.rd_base !== c_buf1 || sdram_bus.wr_base !== c_buf0 || drop_cnt !== 16'd0) begin
            n_fail++; $display("FAIL mid_reset_regs: got rd %h wr %h drop %0d expected %h %h 0", sdram_bus.rd_base, sdram_bus.wr_base, drop_cnt, c_buf1, c_buf0); end
        cam_pix_valid = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_rate();
        for (int f = 0; f < 5; f++) run_frame();
        for (int k = 0; k < 1100 && cyc < 1003; k++) step();
`ifdef FRAME_RATE_EN
        n_checks++; if (rate !== 32'd5) begin n_fail++; $display("FAIL rate: got %0d expected 5", rate); end
`else
        n_checks++; if (rate !== 32'd0) begin n_fail++; $display("FAIL rate_off: got %0d expected 0", rate); end
`endif
        n_checks++; if (sdram_bus.rd_base !== c_buf0) begin n_fail++; $display("FAIL rate_rd_base: got %h expected %h", sdram_bus.rd_base, c_buf0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_capture();
        test_swap();
        test_short_frame();
        test_drop();
        test_simultaneous();
        test_mid_reset();
        test_rate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
